pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and taken-branch redirects.
- Freezes the pipeline while the data memory inserts wait states. MEM/WB has no enable, so it is fed a bubble (RegWrite gated) instead.
- Supervises memory wait time, enters a halted error state on timeout, and keeps saturating stall/flush performance counters.

Parameters:
MAX_WAIT, 4, max consecutive dmem wait cycles tolerated before timeout (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination reg of instruction in EX
ex_MemRead  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
mem_req  in  1  MEM stage instruction accesses dmem
dmem_ready  in  1  dmem completes access this cycle
perf_clr  in  1  synchronous clear of perf counters
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID insert NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX insert bubble (control zeroed)
exmem_en  out  1  EX/MEM load enable
memwb_bubble  out  1  gate RegWrite_in=0 into MEM/WB
err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  cycles with ifid_flush=1

Behaviour:
- Internal signals:
  - mem_stall = mem_req & ~dmem_ready.
  - load_use = ex_MemRead & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- States: RUN, MEM_WAIT, HALT. A wait_cnt register has width clog2(MAX_WAIT+1).
- Control outputs are combinational in the current state and inputs. Priority: rst > HALT > mem_stall > ex_branch_taken > load_use > normal.
- rst=1 (current cycle):
  - Outputs: all enables 0, flushes 0, memwb_bubble 0.
  - Next state: RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0.
- HALT:
  - pc_en=ifid_en=idex_en=exmem_en=0, flushes 0, memwb_bubble=1, err=1.
  - Only rst exits.
- mem_stall=1 (RUN or MEM_WAIT):
  - pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, flushes 0.
  - ex_branch_taken and load_use are ignored; EX is frozen, so both re-present after release.
- ex_branch_taken=1, no mem_stall:
  - All enables 1, ifid_flush=1, idex_flush=1.
  - A simultaneous load_use is discarded; the ID instruction is squashed.
- load_use=1 only:
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
  - Exactly one bubble, since the load leaves EX next cycle.
- Normal: all enables 1, flushes 0, memwb_bubble 0.
- Transitions:
  - RUN, mem_stall=1 -> MEM_WAIT with wait_cnt=1. MAX_WAIT=1 goes directly via the MEM_WAIT rule next cycle.
  - MEM_WAIT, mem_stall=0 -> RUN, wait_cnt=0. That cycle is normal/branch/load-use per priority.
  - MEM_WAIT, mem_stall=1, wait_cnt<MAX_WAIT -> wait_cnt+1.
  - MEM_WAIT, mem_stall=1, wait_cnt==MAX_WAIT -> HALT; err rises next cycle.
  - Net effect: MAX_WAIT stall cycles are tolerated; the (MAX_WAIT+1)th consecutive stall cycle triggers HALT.
- Counters (rst=0):
  - perf_clr=1 -> both 0, overriding increments.
  - Otherwise stall_cnt+1 when pc_en=0 and state!=HALT; flush_cnt+1 when ifid_flush=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- rst mid-MEM_WAIT or in HALT: next cycle RUN, normal outputs if mem_stall=0.
- ex_rd=0 never causes load_use.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 (use_rs2=1): 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cnt=1.
- Load to x0, ID reads x0: no stall, all enables 1, stall_cnt stays 0.
- ex_branch_taken=1 together with load_use=1: ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- MAX_WAIT=4, mem_req=1, dmem_ready low 3 cycles then high: 3 cycles all enables 0, memwb_bubble=1, err=0, stall_cnt=3; resume in RUN.
- MAX_WAIT=4, dmem_ready low 5 consecutive cycles: err=1 from 6th cycle on, enables held 0 indefinitely; rst pulse -> err=0, RUN, counters 0.
- Counters with CNT_W=4: 20 stall cycles (mixed load-use/mem waits) -> stall_cnt=15 held; perf_clr pulse -> 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for a 5-stage pipeline (load-use, branch redirect, dmem wait, timeout halt).
// Latency : control outputs are combinational from current state and inputs; state and counters update next clock.
// Backpress: dmem wait states freeze PC..EX/MEM and bubble MEM/WB; an over-long wait halts until reset.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2/id_use_rs1/2    ID-stage source registers and read flags
//   ex_rd, ex_MemRead             EX-stage destination register and load flag
//   ex_branch_taken               EX resolved a taken branch/jump
//   mem_req, dmem_ready           MEM-stage dmem access and completion
//   perf_clr                      synchronous clear of the perf counters
//   pc_en..memwb_bubble           pipeline register enables, flushes, MEM/WB bubble
//   err                           sticky memory-timeout flag
//   stall_cnt, flush_cnt          saturating perf counters
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]    WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;

  assign mem_stall = mem_req & ~dmem_ready;
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use  = ex_MemRead & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Pipeline control, highest priority first.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      // everything held low
    end else if (state_q == ST_HALT || mem_stall) begin
      // MEM/WB has no enable: keep it from retiring the stalled instruction twice.
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect wins over load-use: the dependent ID instruction is squashed anyway.
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID, inject one bubble into EX; the load moves on next cycle.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

  // Memory-wait supervisor: tolerate MAX_WAIT stall cycles, halt on the next one.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        // only reset leaves
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating perf counters; clear takes precedence over counting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_en && state_q != ST_HALT && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (ifid_flush && flush_cnt_q != CNT_MAX)
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
